uart_rx_capture: RTL and testbench

- Synthesizable UART receiver that consumes the SoC's UART_TXD serial output and turns it into a byte stream for bench checkers and on-board loopback logic.
- Sits directly downstream of the darksocv UART transmitter.
- Oversamples the line with a clock-cycle bit divider and buffers bytes in a small FIFO.
- Offers a ready/valid byte interface and reports framing and overflow errors.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_capture_sync_fifo.sv | 56 +++++
 rtl/uart_rx_capture.sv | 159 +++++++++++++++
 tb/tb_uart_rx_capture.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive-capture block.
package uart_pkg;

    // Default bit period in clock cycles (board clock / baud).
    localparam int CLK_DIV_DEF = 868;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_capture_sync_fifo.sv
// First-word-fallthrough FIFO with wrap-bit pointers. A push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                   CLK,
    input  logic                   RES,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    // Status flags, accepted push/pop and next pointer values.
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = ((wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}});
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        level   = wptr_q - rptr_q;
        // Head is forced to zero when nothing is stored.
        dout    = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge CLK) begin
        if (RES) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array: written only on an accepted push, needs no reset.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_capture.sv
// UART receiver: synchronizes RXD, frames 8N1 bytes with a mid-bit sampling
// counter, and queues good bytes in a FIFO behind a ready/valid interface.
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int DEPTH   = 16,
    parameter int LW      = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          RXD,
    output logic [7:0]    DATA_O,
    output logic          VALID_O,
    input  logic          READY_I,
    output logic          FERR_O,
    output logic          OVF_O,
    input  logic          CLR_I,
    output logic [LW-1:0] LEVEL_O
);

    localparam int          CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2 - 1);

    logic        sync1_q, sync2_q;
    logic        rxs;
    rx_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bi_q, bi_d;
    byte_t       shreg_q, shreg_d;
    logic        push_q, push_d;
    logic        ferr_q, ferr_d;
    logic        ovf_q, ovf_d;
    logic        fifo_full, fifo_empty, pop;
    byte_t       fifo_dout;

    assign rxs = sync2_q;

    // Two-flop synchronizer; preset high so reset looks like an idle line.
    always_ff @(posedge CLK) begin
        if (RES) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= RXD;
            sync2_q <= sync1_q;
        end
    end

    // Frame decoder next-state logic; push and error strobes are one-cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bi_d    = bi_q;
        shreg_d = shreg_q;
        push_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    cnt_d   = CNT_HALF;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    // Start bit did not survive to mid-bit: treat as a glitch.
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = CNT_FULL;
                    bi_d    = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d[bi_q] = rxs;
                    cnt_d         = CNT_FULL;
                    bi_d          = bi_q + 3'd1;
                    if (bi_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    push_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = ST_BREAK;
                end
            end
            ST_BREAK: begin
                // Held-low line: wait for idle so only one error is reported.
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Overflow is sticky; a new overflow beats a same-cycle clear.
    always_comb begin
        ovf_d = (push_q & fifo_full & ~pop) | (ovf_q & ~CLR_I);
    end

    // Frame decoder and status registers.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bi_q    <= 3'd0;
            shreg_q <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bi_q    <= bi_d;
            shreg_q <= shreg_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pop = ~fifo_empty & READY_I;

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     (8)
    ) u_fifo (
        .CLK   (CLK),
        .RES   (RES),
        .push  (push_q),
        .din   (shreg_q),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (LEVEL_O)
    );

    assign DATA_O  = fifo_dout;
    assign VALID_O = ~fifo_empty;
    assign FERR_O  = ferr_q;
    assign OVF_O   = ovf_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture with CLK_DIV=16, DEPTH=4.
module tb_uart_rx_capture;
    import uart_pkg::*;

    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 4;
    localparam int LW      = 3;

    logic          CLK = 1'b0;
    logic          RES = 1'b1;
    logic          RXD = 1'b1;
    logic          READY_I = 1'b0;
    logic          CLR_I = 1'b0;
    logic [7:0]    DATA_O;
    logic          VALID_O, FERR_O, OVF_O;
    logic [LW-1:0] LEVEL_O;

    int n_chk = 0;
    int n_err = 0;
    int ferr_cnt = 0;
    int vld_cyc = 0;
    byte_t got[$];

    always #5 CLK = ~CLK;

    uart_rx_capture #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH),
        .LW      (LW)
    ) dut (
        .CLK     (CLK),
        .RES     (RES),
        .RXD     (RXD),
        .DATA_O  (DATA_O),
        .VALID_O (VALID_O),
        .READY_I (READY_I),
        .FERR_O  (FERR_O),
        .OVF_O   (OVF_O),
        .CLR_I   (CLR_I),
        .LEVEL_O (LEVEL_O)
    );

    // Event monitor: error pulses, valid cycles and popped bytes.
    always @(posedge CLK) begin
        if (!RES) begin
            if (FERR_O) ferr_cnt <= ferr_cnt + 1;
            if (VALID_O) vld_cyc <= vld_cyc + 1;
            if (VALID_O && READY_I) got.push_back(DATA_O);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame, 160 cycles; optional one-cycle READY_I pulse at cycle rdy_at.
    task automatic send(input byte_t b, input logic stop, input int rdy_at);
        for (int k = 0; k < 160; k++) begin
            if (k < 16)       RXD = 1'b0;
            else if (k < 144) RXD = b[(k - 16) / 16];
            else              RXD = stop;
            if (rdy_at >= 0) READY_I = (k == rdy_at);
            @(negedge CLK);
        end
    endtask

    task automatic drain();
        READY_I = 1'b1;
        repeat (8) @(negedge CLK);
        READY_I = 1'b0;
    endtask

    initial begin
        int gb, fb, vb;
        byte_t b6;
        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_valid", VALID_O, 0);
        chk("rst_data",  DATA_O,  0);
        chk("rst_ferr",  FERR_O,  0);
        chk("rst_ovf",   OVF_O,   0);
        chk("rst_level", LEVEL_O, 0);
        RES = 1'b0;
        repeat (4) @(negedge CLK);

        // Single byte, consumer always ready
        gb = got.size(); fb = ferr_cnt; vb = vld_cyc;
        READY_I = 1'b1;
        send(8'hA5, 1'b1, -1);
        repeat (4) @(negedge CLK);
        READY_I = 1'b0;
        chk("t1_npop",  got.size() - gb, 1);
        chk("t1_data",  got[gb], 8'hA5);
        chk("t1_vcyc",  vld_cyc - vb, 1);
        chk("t1_ferr",  ferr_cnt - fb, 0);
        chk("t1_level", LEVEL_O, 0);

        // Back-to-back bytes with consumer stalled
        gb = got.size();
        send(8'h55, 1'b1, -1);
        chk("t2_lvl1", LEVEL_O, 1);
        send(8'h00, 1'b1, -1);
        chk("t2_lvl2", LEVEL_O, 2);
        send(8'hFF, 1'b1, -1);
        chk("t2_lvl3", LEVEL_O, 3);
        chk("t2_head", DATA_O, 8'h55);
        chk("t2_valid", VALID_O, 1);
        drain();
        chk("t2_npop", got.size() - gb, 3);
        chk("t2_pop0", got[gb],     8'h55);
        chk("t2_pop1", got[gb + 1], 8'h00);
        chk("t2_pop2", got[gb + 2], 8'hFF);
        chk("t2_lvl0", LEVEL_O, 0);

        // Overflow on the fifth byte, then clear
        gb = got.size();
        for (int i = 1; i <= 4; i++) send(byte_t'(i), 1'b1, -1);
        chk("t3_ovf_pre", OVF_O, 0);
        send(8'h05, 1'b1, -1);
        chk("t3_level", LEVEL_O, 4);
        chk("t3_ovf",   OVF_O, 1);
        chk("t3_head",  DATA_O, 8'h01);
        CLR_I = 1'b1;
        @(negedge CLK);
        CLR_I = 1'b0;
        chk("t3_clr", OVF_O, 0);
        drain();
        chk("t3_npop", got.size() - gb, 4);
        chk("t3_last", got[gb + 3], 8'h04);

        // Bad stop bit, line held low, then recovery
        fb = ferr_cnt;
        send(8'h81, 1'b0, -1);
        repeat (40) @(negedge CLK);
        RXD = 1'b1;
        repeat (8) @(negedge CLK);
        chk("t4_ferr",  ferr_cnt - fb, 1);
        chk("t4_level", LEVEL_O, 0);
        send(8'h3C, 1'b1, -1);
        chk("t4_lvl1", LEVEL_O, 1);
        chk("t4_data", DATA_O, 8'h3C);
        drain();

        // Short glitch on idle line
        fb = ferr_cnt;
        RXD = 1'b0;
        repeat (4) @(negedge CLK);
        RXD = 1'b1;
        repeat (20) @(negedge CLK);
        chk("t5_glitch_lvl", LEVEL_O, 0);
        chk("t5_glitch_st",  dut.state_q, ST_IDLE);
        chk("t5_glitch_fe",  ferr_cnt - fb, 0);

        // Reset in the middle of bit 4 of a frame
        send(8'h99, 1'b1, -1);
        chk("t5_pre_lvl", LEVEL_O, 1);
        b6 = 8'h6B;
        RXD = 1'b0;
        repeat (16) @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            RXD = b6[i];
            repeat (16) @(negedge CLK);
        end
        RXD = b6[4];
        repeat (8) @(negedge CLK);
        RES = 1'b1;
        RXD = 1'b1;
        repeat (2) @(negedge CLK);
        RES = 1'b0;
        @(negedge CLK);
        chk("t5_rst_lvl", LEVEL_O, 0);
        chk("t5_rst_vld", VALID_O, 0);
        chk("t5_rst_st",  dut.state_q, ST_IDLE);
        repeat (10) @(negedge CLK);
        send(8'h7E, 1'b1, -1);
        chk("t5_lvl1", LEVEL_O, 1);
        chk("t5_data", DATA_O, 8'h7E);
        drain();

        // Full FIFO, push and pop in the same cycle
        gb = got.size();
        send(8'h11, 1'b1, -1);
        send(8'h22, 1'b1, -1);
        send(8'h33, 1'b1, -1);
        send(8'h44, 1'b1, -1);
        chk("t6_full", LEVEL_O, 4);
        send(8'h55, 1'b1, 155);
        chk("t6_level", LEVEL_O, 4);
        chk("t6_ovf",   OVF_O, 0);
        chk("t6_head",  DATA_O, 8'h22);
        drain();
        chk("t6_npop",  got.size() - gb, 5);
        chk("t6_first", got[gb], 8'h11);
        chk("t6_last",  got[gb + 4], 8'h55);
        chk("t6_lvl0",  LEVEL_O, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
